// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: FSM states, access-size codes,
// alignment check, byte-enable generation and store-data lane replication (64-bit max, callers truncate).
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic aligned(input logic [2:0] lo, input logic [1:0] size, input logic dw64);
    case (size)
      SZ_B:    aligned = 1'b1;
      SZ_H:    aligned = (lo[0] == 1'b0);
      SZ_W:    aligned = (lo[1:0] == 2'b00);
      default: aligned = dw64 && (lo == 3'b000);
    endcase
  endfunction

  function automatic logic [7:0] gen_be(input logic [2:0] off, input logic [1:0] size);
    case (size)
      SZ_B:    gen_be = 8'h01 << off;
      SZ_H:    gen_be = 8'h03 << off;
      SZ_W:    gen_be = 8'h0F << off;
      default: gen_be = 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] repl_wdata(input logic [63:0] d, input logic [1:0] size);
    case (size)
      SZ_B:    repl_wdata = {8{d[7:0]}};
      SZ_H:    repl_wdata = {4{d[15:0]}};
      SZ_W:    repl_wdata = {2{d[31:0]}};
      default: repl_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid bus. master = LSU, slave = memory; memory may stall via gnt/rvalid.
interface mem_stage_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  localparam int BE_W = DATA_W / 8;

  logic              req;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Load extraction: shift the memory word down to the byte offset, then sign/zero-extend by size.
// Purely combinational, no backpressure.
module lsu_align import mem_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]             rdata_i,
  input  logic [$clog2(DATA_W/8)-1:0]   off_i,
  input  logic [1:0]                    size_i,
  input  logic                          unsigned_i,
  output logic [DATA_W-1:0]             result_o
);
  logic [63:0] sh;
  logic [63:0] ext;
  logic        sx;

  // Extension is built at 64 bits; for DATA_W=32 the word case truncates away, so unsigned is moot there.
  always_comb begin
    sh = 64'(rdata_i >> {off_i, 3'b000});
    sx = ~unsigned_i;
    case (size_i)
      SZ_B:    ext = {{56{sx & sh[7]}},  sh[7:0]};
      SZ_H:    ext = {{48{sx & sh[15]}}, sh[15:0]};
      SZ_W:    ext = {{32{sx & sh[31]}}, sh[31:0]};
      default: ext = sh;
    endcase
    result_o = DATA_W'(ext);
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: registers EX->WB results and runs loads/stores over a req/gnt/rvalid memory bus.
// Latency 1 cycle for ALU/misaligned ops, memory-dependent otherwise; stall_o holds EX until completion.
module mem_stage_lsu import mem_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int BE_W       = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  input  logic                  write_reg_en_i,
  input  logic [REG_ADDR_W-1:0] write_reg_addr_i,
  input  logic [DATA_W-1:0]     write_reg_data_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  mem_unsigned_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  output logic                  stall_o,
  mem_stage_lsu_if.master       dmem,
  output logic                  wb_valid_o,
  output logic                  write_reg_en_o,
  output logic [REG_ADDR_W-1:0] write_reg_addr_o,
  output logic [DATA_W-1:0]     write_reg_data_o,
  output logic                  misalign_o
);
  localparam int   OFF_W = $clog2(BE_W);
  localparam logic DW64  = (DATA_W == 64);

  state_e state_q, state_d;
  logic req_q, req_d, we_q, we_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic wb_valid_q, wb_valid_d, wr_en_q, wr_en_d, misalign_q, misalign_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d, ld_rd_q, ld_rd_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic ld_en_q, ld_en_d, ld_uns_q, ld_uns_d;
  logic [1:0] ld_size_q, ld_size_d;
  logic [OFF_W-1:0] ld_off_q, ld_off_d;

  logic memop, is_aligned, issue;
  logic [DATA_W-1:0] load_data;

  assign memop      = ex_valid_i & (mem_read_i | mem_write_i);
  assign is_aligned = aligned(mem_addr_i[2:0], mem_size_i, DW64);
  assign issue      = memop & is_aligned;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .rdata_i   (dmem.rdata),
    .off_i     (ld_off_q),
    .size_i    (ld_size_q),
    .unsigned_i(ld_uns_q),
    .result_o  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = REQ;
      REQ:     if (dmem.gnt) state_d = we_q ? IDLE : WAIT;
      WAIT:    if (dmem.rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;  we_d = we_q;  be_d = be_q;  addr_d = addr_q;  wdata_d = wdata_q;
    wb_valid_d = 1'b0;  wr_en_d = 1'b0;  misalign_d = 1'b0;
    wr_addr_d = wr_addr_q;  wr_data_d = wr_data_q;
    ld_en_d = ld_en_q;  ld_rd_d = ld_rd_q;  ld_size_d = ld_size_q;
    ld_uns_d = ld_uns_q;  ld_off_d = ld_off_q;
    case (state_q)
      IDLE: if (ex_valid_i) begin
        if (!memop) begin
          wb_valid_d = 1'b1;
          wr_en_d    = write_reg_en_i;
          wr_addr_d  = write_reg_addr_i;
          wr_data_d  = write_reg_data_i;
        end else if (!is_aligned) begin
          wb_valid_d = 1'b1;
          misalign_d = 1'b1;
          wr_addr_d  = write_reg_addr_i;
        end else begin
          // A read+write combination is a store: we follows mem_write_i alone.
          req_d     = 1'b1;
          we_d      = mem_write_i;
          be_d      = BE_W'(gen_be(3'(mem_addr_i[OFF_W-1:0]), mem_size_i));
          addr_d    = mem_addr_i & ~ADDR_W'(BE_W - 1);
          wdata_d   = DATA_W'(repl_wdata(64'(mem_wdata_i), mem_size_i));
          ld_en_d   = write_reg_en_i;
          ld_rd_d   = write_reg_addr_i;
          ld_size_d = mem_size_i;
          ld_uns_d  = mem_unsigned_i;
          ld_off_d  = mem_addr_i[OFF_W-1:0];
        end
      end
      REQ: if (dmem.gnt) begin
        req_d = 1'b0;
        if (we_q) wb_valid_d = 1'b1;
      end
      WAIT: if (dmem.rvalid) begin
        wb_valid_d = 1'b1;
        wr_en_d    = ld_en_q;
        wr_addr_d  = ld_rd_q;
        wr_data_d  = load_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;  we_q <= 1'b0;  be_q <= '0;  addr_q <= '0;  wdata_q <= '0;
      wb_valid_q <= 1'b0;  wr_en_q <= 1'b0;  misalign_q <= 1'b0;
      wr_addr_q <= '0;  wr_data_q <= '0;
      ld_en_q <= 1'b0;  ld_rd_q <= '0;  ld_size_q <= SZ_B;  ld_uns_q <= 1'b0;  ld_off_q <= '0;
    end else begin
      req_q <= req_d;  we_q <= we_d;  be_q <= be_d;  addr_q <= addr_d;  wdata_q <= wdata_d;
      wb_valid_q <= wb_valid_d;  wr_en_q <= wr_en_d;  misalign_q <= misalign_d;
      wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;
      ld_en_q <= ld_en_d;  ld_rd_q <= ld_rd_d;  ld_size_q <= ld_size_d;
      ld_uns_q <= ld_uns_d;  ld_off_q <= ld_off_d;
    end
  end

  // Low in the completion cycle so EX advances on the same edge the result is registered.
  assign stall_o = ((state_q == IDLE) & issue) |
                   ((state_q == REQ)  & ~(dmem.gnt & we_q)) |
                   ((state_q == WAIT) & ~dmem.rvalid);

  assign dmem.req         = req_q;
  assign dmem.we          = we_q;
  assign dmem.be          = be_q;
  assign dmem.addr        = addr_q;
  assign dmem.wdata       = wdata_q;
  assign wb_valid_o       = wb_valid_q;
  assign write_reg_en_o   = wr_en_q;
  assign write_reg_addr_o = wr_addr_q;
  assign write_reg_data_o = wr_data_q;
  assign misalign_o       = misalign_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (DATA_W=32): ALU pass-through, loads, stores with wait states,
// misaligned accesses and reset during an outstanding load.
module tb_mem_stage_lsu;
  import mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic ex_valid, wr_en_i, mem_read, mem_write, mem_uns;
  logic [RW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i, mem_wdata;
  logic [1:0] mem_size;
  logic [AW-1:0] mem_addr;
  logic stall, wb_valid, wr_en_o, misalign;
  logic [RW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;

  mem_stage_lsu_if #(.DATA_W(DW), .ADDR_W(AW)) dmem ();

  mem_stage_lsu #(.DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid), .write_reg_en_i(wr_en_i), .write_reg_addr_i(wr_addr_i),
    .write_reg_data_i(wr_data_i), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .mem_size_i(mem_size), .mem_unsigned_i(mem_uns), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .stall_o(stall), .dmem(dmem),
    .wb_valid_o(wb_valid), .write_reg_en_o(wr_en_o), .write_reg_addr_o(wr_addr_o),
    .write_reg_data_o(wr_data_o), .misalign_o(misalign)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; wr_en_i = 0; wr_addr_i = '0; wr_data_i = '0; mem_read = 0; mem_write = 0;
    mem_size = SZ_B; mem_uns = 0; mem_addr = '0; mem_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    dmem.gnt = 0; dmem.rvalid = 0; dmem.rdata = '0;
    #2 rst_n = 0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0 || wr_en_o !== 1'b0 || misalign !== 1'b0) begin n_err++; $display("FAIL reset_wb: valid=%b en=%b mis=%b want 0", wb_valid, wr_en_o, misalign); end
    n_cmp++; if (wr_addr_o !== '0 || wr_data_o !== '0) begin n_err++; $display("FAIL reset_wbdata: addr=%h data=%h want 0", wr_addr_o, wr_data_o); end
    n_cmp++; if ({dmem.req, dmem.we, dmem.be, dmem.addr, dmem.wdata} !== '0) begin n_err++; $display("FAIL reset_dmem: req=%b we=%b be=%h addr=%h wdata=%h want 0", dmem.req, dmem.we, dmem.be, dmem.addr, dmem.wdata); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    repeat (2) step();
    @(negedge clk) rst_n = 1;
    step();
  endtask

  task automatic test_alu();
    ex_valid = 1; wr_en_i = 1; wr_addr_i = 5'd5; wr_data_i = 32'h1234;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b want 0", stall); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wr_en_o !== 1'b1 || misalign !== 1'b0) begin n_err++; $display("FAIL alu_ctrl: valid=%b en=%b mis=%b want 1 1 0", wb_valid, wr_en_o, misalign); end
    n_cmp++; if (wr_addr_o !== 5'd5 || wr_data_o !== 32'h1234) begin n_err++; $display("FAIL alu_data: rd=%0d data=%h want 5 1234", wr_addr_o, wr_data_o); end
    n_cmp++; if (dmem.req !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL alu_noreq: req=%b stall=%b want 0 0", dmem.req, stall); end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1; wr_en_i = 0; wr_addr_i = 5'd12; wr_data_i = 32'h5A5A_0001;
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wr_en_o !== 1'b0 || wr_addr_o !== 5'd12 || wr_data_o !== 32'h5A5A_0001) begin n_err++; $display("FAIL b2b_second: valid=%b en=%b rd=%0d data=%h want 1 0 12 5a5a0001", wb_valid, wr_en_o, wr_addr_o, wr_data_o); end
    idle_inputs();
    step();
    n_cmp++; if (wb_valid !== 1'b0 || wr_en_o !== 1'b0) begin n_err++; $display("FAIL b2b_bubble: valid=%b en=%b want 0 0", wb_valid, wr_en_o); end
  endtask

  task automatic test_load(input string nm, input logic [31:0] addr, input logic [1:0] sz,
                           input logic uns, input logic [RW-1:0] rd, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_data,
                           input int gnt_dly, input int rv_dly);
    ex_valid = 1; mem_read = 1; mem_write = 0; mem_size = sz; mem_uns = uns; mem_addr = addr;
    wr_en_i = 1; wr_addr_i = rd; wr_data_i = 32'hDEAD_DEAD;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL %s issue_stall: got %b want 1", nm, stall); end
    step();
    n_cmp++; if (dmem.req !== 1'b1 || dmem.we !== 1'b0 || dmem.be !== exp_be || dmem.addr !== (addr & 32'hFFFF_FFFC)) begin n_err++; $display("FAIL %s req: req=%b we=%b be=%b addr=%h want 1 0 %b %h", nm, dmem.req, dmem.we, dmem.be, dmem.addr, exp_be, addr & 32'hFFFF_FFFC); end
    for (int i = 0; i < gnt_dly; i++) begin
      step();
      n_cmp++; if (dmem.req !== 1'b1 || stall !== 1'b1 || wb_valid !== 1'b0) begin n_err++; $display("FAIL %s gnt_wait: req=%b stall=%b valid=%b want 1 1 0", nm, dmem.req, stall, wb_valid); end
    end
    dmem.gnt = 1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL %s gnt_stall: got %b want 1", nm, stall); end
    step();
    dmem.gnt = 0;
    n_cmp++; if (dmem.req !== 1'b0 || stall !== 1'b1) begin n_err++; $display("FAIL %s after_gnt: req=%b stall=%b want 0 1", nm, dmem.req, stall); end
    for (int i = 0; i < rv_dly; i++) begin
      step();
      n_cmp++; if (stall !== 1'b1 || wb_valid !== 1'b0) begin n_err++; $display("FAIL %s rv_wait: stall=%b valid=%b want 1 0", nm, stall, wb_valid); end
    end
    dmem.rvalid = 1; dmem.rdata = rdata;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL %s rv_stall: got %b want 0", nm, stall); end
    idle_inputs();
    step();
    dmem.rvalid = 0; dmem.rdata = '0;
    n_cmp++; if (wb_valid !== 1'b1 || wr_en_o !== 1'b1 || wr_addr_o !== rd || misalign !== 1'b0) begin n_err++; $display("FAIL %s wb: valid=%b en=%b rd=%0d mis=%b want 1 1 %0d 0", nm, wb_valid, wr_en_o, wr_addr_o, misalign, rd); end
    n_cmp++; if (wr_data_o !== exp_data) begin n_err++; $display("FAIL %s data: got %h want %h", nm, wr_data_o, exp_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL %s bubble: got %b want 0", nm, wb_valid); end
  endtask

  task automatic test_store(input string nm, input logic [31:0] addr, input logic [1:0] sz,
                            input logic also_rd, input logic [31:0] wdata,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata, input int gnt_dly);
    ex_valid = 1; mem_read = also_rd; mem_write = 1; mem_size = sz; mem_addr = addr;
    mem_wdata = wdata; wr_en_i = 1; wr_addr_i = 5'd9;
    step();
    // Upstream garbage while the request is outstanding must not leak onto the bus.
    mem_addr = 32'hDEAD_BEE1; mem_wdata = 32'h0; mem_size = SZ_B;
    for (int i = 0; i < gnt_dly + 1; i++) begin
      n_cmp++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1 || dmem.be !== exp_be || dmem.addr !== (addr & 32'hFFFF_FFFC) || dmem.wdata !== exp_wdata) begin n_err++; $display("FAIL %s hold%0d: req=%b we=%b be=%b addr=%h wdata=%h want 1 1 %b %h %h", nm, i, dmem.req, dmem.we, dmem.be, dmem.addr, dmem.wdata, exp_be, addr & 32'hFFFF_FFFC, exp_wdata); end
      n_cmp++; if (stall !== 1'b1 || wb_valid !== 1'b0) begin n_err++; $display("FAIL %s wait%0d: stall=%b valid=%b want 1 0", nm, i, stall, wb_valid); end
      if (i < gnt_dly) step();
    end
    dmem.gnt = 1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL %s gnt_stall: got %b want 0", nm, stall); end
    idle_inputs();
    step();
    dmem.gnt = 0;
    n_cmp++; if (dmem.req !== 1'b0 || wb_valid !== 1'b1 || wr_en_o !== 1'b0 || misalign !== 1'b0) begin n_err++; $display("FAIL %s done: req=%b valid=%b en=%b mis=%b want 0 1 0 0", nm, dmem.req, wb_valid, wr_en_o, misalign); end
    step();
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [4] = '{32'h1001, 32'h1003, 32'h1000, 32'h2001};
    logic [1:0]  sizes [4] = '{SZ_W, SZ_H, SZ_D, SZ_H};
    logic        wr    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1; mem_read = ~wr[i]; mem_write = wr[i]; mem_size = sizes[i]; mem_addr = addrs[i];
      wr_en_i = 1; wr_addr_i = 5'd3;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL misalign%0d_stall: got %b want 0", i, stall); end
      step();
      n_cmp++; if (dmem.req !== 1'b0 || wb_valid !== 1'b1 || misalign !== 1'b1 || wr_en_o !== 1'b0) begin n_err++; $display("FAIL misalign%0d: req=%b valid=%b mis=%b en=%b want 0 1 1 0", i, dmem.req, wb_valid, misalign, wr_en_o); end
      idle_inputs();
      step();
      n_cmp++; if (misalign !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL misalign%0d_clear: mis=%b valid=%b want 0 0", i, misalign, wb_valid); end
    end
  endtask

  task automatic test_reset_in_wait();
    ex_valid = 1; mem_read = 1; mem_size = SZ_W; mem_addr = 32'h3000; wr_en_i = 1; wr_addr_i = 5'd20;
    step();
    dmem.gnt = 1;
    step();
    dmem.gnt = 0;
    idle_inputs();
    n_cmp++; if (stall !== 1'b1 || dmem.req !== 1'b0) begin n_err++; $display("FAIL rstw_inwait: stall=%b req=%b want 1 0", stall, dmem.req); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (stall !== 1'b0 || dmem.req !== 1'b0 || dmem.be !== '0 || dmem.addr !== '0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL rstw_async: stall=%b req=%b be=%b addr=%h valid=%b want all 0", stall, dmem.req, dmem.be, dmem.addr, wb_valid); end
    dmem.rvalid = 1; dmem.rdata = 32'h1234_5678;
    repeat (2) step();
    @(negedge clk) rst_n = 1;
    step();
    dmem.rvalid = 0;
    n_cmp++; if (wb_valid !== 1'b0 || wr_data_o !== '0 || stall !== 1'b0) begin n_err++; $display("FAIL rstw_late_rvalid: valid=%b data=%h stall=%b want 0 0 0", wb_valid, wr_data_o, stall); end
    ex_valid = 1; wr_en_i = 1; wr_addr_i = 5'd9; wr_data_i = 32'hABCD;
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wr_en_o !== 1'b1 || wr_addr_o !== 5'd9 || wr_data_o !== 32'hABCD) begin n_err++; $display("FAIL rstw_recover: valid=%b en=%b rd=%0d data=%h want 1 1 9 abcd", wb_valid, wr_en_o, wr_addr_o, wr_data_o); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load("lb_1003",  32'h1003, SZ_B, 1'b0, 5'd7,  32'h80AA5511, 4'b1000, 32'hFFFF_FF80, 1, 1);
    test_load("lhu_1002", 32'h1002, SZ_H, 1'b1, 5'd8,  32'hBEEF1234, 4'b1100, 32'h0000_BEEF, 0, 0);
    test_load("lh_1002",  32'h1002, SZ_H, 1'b0, 5'd10, 32'hBEEF1234, 4'b1100, 32'hFFFF_BEEF, 0, 2);
    test_load("lbu_1001", 32'h1001, SZ_B, 1'b1, 5'd11, 32'h80AA5511, 4'b0010, 32'h0000_0055, 2, 0);
    test_load("lb_1002",  32'h1002, SZ_B, 1'b0, 5'd13, 32'h80AA5511, 4'b0100, 32'hFFFF_FFAA, 0, 1);
    test_load("lwu_1004", 32'h1004, SZ_W, 1'b1, 5'd31, 32'h80000001, 4'b1111, 32'h8000_0001, 2, 1);
    test_store("sw_2000", 32'h2000, SZ_W, 1'b0, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 3);
    test_store("sb_2001", 32'h2001, SZ_B, 1'b0, 32'h123456AB, 4'b0010, 32'hABABABAB, 0);
    test_store("sh_2006", 32'h2006, SZ_H, 1'b1, 32'hFFFF1234, 4'b1100, 32'h12341234, 1);
    test_misalign();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
